md_seq_ctrl: RTL and testbench
==============================

// Module: md_seq_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer beside the single-cycle EX ALU. Accepts MULT/MULTU/DIV/DIVU,
//  iterates 32 cycles (shift-add / restoring divide), owns the HI/LO registers and raises stall_req
//  so the pipeline holds ID/EX while an operation is in flight. Also serves MTHI/MTLO writes.
// PARAMETERS
//  DATA_W  32  operand/HI/LO width (= REG_LENGTH)
//  CNT_W   6   iteration counter width; must hold DATA_W
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       reset, synchronous, active-high
//  start      in   1       request; sampled only in IDLE
//  md_op      in   2       MD_OP_MULT=0, MD_OP_MULTU=1, MD_OP_DIV=2, MD_OP_DIVU=3
//  srcA       in   DATA_W  multiplicand / dividend
//  srcB       in   DATA_W  multiplier / divisor
//  flush      in   1       abort in-flight op (branch/exception flush)
//  hilo_we    in   2       [1]=MTHI, [0]=MTLO write enable
//  hilo_wdata in   DATA_W  MTHI/MTLO data
//  busy       out  1       registered; 1 in states MUL, DIV
//  stall_req  out  1       comb; busy | (start & state==IDLE)
//  done       out  1       1-cycle pulse; HI/LO valid with new result
//  div_by_zero out 1       qualifies done; divisor was zero
//  hi, lo     out  DATA_W  HI/LO registers
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, busy=done=div_by_zero=0, counter=0; overrides every other input.
//  FSM: IDLE -start&MULT(U)-> MUL; IDLE -start&DIV(U)&srcB!=0-> DIV; IDLE -start&DIV(U)&srcB==0-> DONE;
//   MUL/DIV -counter==0-> DONE; DONE -> IDLE (unconditional); flush in MUL/DIV/DONE -> IDLE.
//  Timing: start sampled at edge N (operands latched) -> iterations N+1..N+32 -> hi/lo written at edge
//   entering DONE -> done=1 during cycle N+33 -> IDLE. New start accepted from the IDLE cycle N+34.
//  Signed ops: latch |srcA|,|srcB| plus sign bits; fix signs at final step. MULT: 64-bit product negated
//   if signs differ; hi=prod[63:32], lo=prod[31:0]. DIV: lo=quotient (neg if signs differ),
//   hi=remainder (sign of dividend). Unsigned ops: no sign fix. 0x80000000 magnitude handled as 2^31.
//  Divide by zero: no iterations; done and div_by_zero both 1 in cycle N+1; hi/lo unchanged.
//  start while not IDLE: ignored (no queueing). flush in IDLE: no effect.
//  flush mid-op: next cycle IDLE, busy=0, no done, hi/lo unchanged. flush wins over counter==0 same cycle.
//  hilo_we honoured in IDLE and DONE only; ignored in MUL/DIV (decoder stalls on stall_req).
//  hilo_we and start same IDLE cycle: hilo write takes effect; op still starts; result overwrites later.
//  Result write in DONE-entry edge has priority over nothing else (hilo_we impossible in MUL/DIV).
// CONFIGURATION
//  MD_DIV_EN defined: full DIV/DIVU support as above.
//  MD_DIV_EN undefined: divider datapath omitted; DIV/DIVU go IDLE->DONE, done pulses cycle N+1,
//   hi/lo unchanged, div_by_zero tied 0.
// STRUCTURE
//  MIPS.vh: MD_OP_* codes, MD_ST_IDLE/MUL/DIV/DONE state encodings, MD_OP_LENGTH.
//  Sub-module md_div_step: combinational restoring-divide step
//   (rem,quo,divisor) -> (rem',quo'); instantiated under MD_DIV_EN only.
// TESTING
//  1 MULTU 0xFFFFFFFF x 0x2 -> done exactly cycle N+33; hi=0x00000001, lo=0xFFFFFFFE; busy N+1..N+32.
//  2 MULT 0xFFFFFFFD(-3) x 0x7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
//  3 DIVU 100/7 -> lo=14, hi=2; DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  4 DIV 5/0 with hi=0xAA,lo=0xBB -> done=div_by_zero=1 in cycle N+1; hi=0xAA, lo=0xBB.
//  5 MULTU 3x4, flush at N+10 -> busy=0 N+11, no done, hi/lo unchanged; 2nd start at N+11 completes N+44.
//  6 rst at N+5 of DIV -> next cycle all outputs 0/IDLE; MTHI 0x1234 in IDLE -> hi=0x1234 next cycle;
//    MTLO during MUL -> ignored.

Source files
------------

// File: rtl/md_seq_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM state encodings and default widths.
package md_seq_ctrl_pkg;

  localparam int MD_DATA_W    = 32;
  localparam int MD_CNT_W     = 6;
  localparam int MD_OP_LENGTH = 2;

  localparam logic [MD_OP_LENGTH-1:0] MD_OP_MULT  = 2'd0;
  localparam logic [MD_OP_LENGTH-1:0] MD_OP_MULTU = 2'd1;
  localparam logic [MD_OP_LENGTH-1:0] MD_OP_DIV   = 2'd2;
  localparam logic [MD_OP_LENGTH-1:0] MD_OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_MUL  = 2'd1,
    MD_ST_DIV  = 2'd2,
    MD_ST_DONE = 2'd3
  } md_state_e;

  function automatic logic md_op_is_div(input logic [MD_OP_LENGTH-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic md_op_is_signed(input logic [MD_OP_LENGTH-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/md_div_step.sv
// One combinational restoring-divide step on unsigned magnitudes:
// shift the next dividend bit into the remainder and subtract if it fits.
module md_div_step
  import md_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_quo,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_quo
);

  logic [DATA_W:0] w_trial;
  logic [DATA_W:0] w_diff;
  logic            w_fits;

  // Remainder stays below the divisor, so a clear borrow bit means the trial fits.
  assign w_trial = {i_rem, i_quo[DATA_W-1]};
  assign w_diff  = w_trial - {1'b0, i_divisor};
  assign w_fits  = ~w_diff[DATA_W];

  assign o_rem = w_fits ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign o_quo = {i_quo[DATA_W-2:0], w_fits};

endmodule

// File: rtl/md_seq_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall request.
// Define MD_DIV_EN to include the restoring divider; otherwise DIV/DIVU complete at once with HI/LO unchanged.
module md_seq_ctrl
  import md_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W,
  parameter int CNT_W  = MD_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MD_OP_LENGTH-1:0] md_op,
  input  logic [DATA_W-1:0]       srcA,
  input  logic [DATA_W-1:0]       srcB,
  input  logic                    flush,
  input  logic [1:0]              hilo_we,
  input  logic [DATA_W-1:0]       hilo_wdata,
  output logic                    busy,
  output logic                    stall_req,
  output logic                    done,
  output logic                    div_by_zero,
  output logic [DATA_W-1:0]       hi,
  output logic [DATA_W-1:0]       lo
);

  md_state_e           r_state, w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_acc_hi, r_acc_lo, r_opnd;
  logic [DATA_W-1:0]   r_hi, r_lo;
  logic                r_neg_res;

  logic                w_is_div, w_a_neg, w_b_neg;
  logic [DATA_W-1:0]   w_a_mag, w_b_mag;
  logic [DATA_W:0]     w_mul_sum;
  logic [DATA_W-1:0]   w_mul_hi, w_mul_lo;
  logic [2*DATA_W-1:0] w_prod, w_prod_fix;

  assign w_is_div = md_op_is_div(md_op);
  assign w_a_neg  = md_op_is_signed(md_op) & srcA[DATA_W-1];
  assign w_b_neg  = md_op_is_signed(md_op) & srcB[DATA_W-1];
  // Unsigned negation maps 0x80000000 onto itself, i.e. the magnitude 2^31.
  assign w_a_mag  = w_a_neg ? -srcA : srcA;
  assign w_b_mag  = w_b_neg ? -srcB : srcB;

  // Shift-add step: acc_hi is the partial product, acc_lo the remaining multiplier bits.
  assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_hi   = w_mul_sum[DATA_W:1];
  assign w_mul_lo   = {w_mul_sum[0], r_acc_lo[DATA_W-1:1]};
  assign w_prod     = {w_mul_hi, w_mul_lo};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;

`ifdef MD_DIV_EN
  logic              r_neg_rem, r_dbz;
  logic              w_b_zero;
  logic [DATA_W-1:0] w_div_rem, w_div_quo, w_quo_fix, w_rem_fix;

  assign w_b_zero = (srcB == '0);

  md_div_step #(.DATA_W(DATA_W)) u_div_step (
    .i_rem     (r_acc_hi),
    .i_quo     (r_acc_lo),
    .i_divisor (r_opnd),
    .o_rem     (w_div_rem),
    .o_quo     (w_div_quo)
  );

  assign w_quo_fix   = r_neg_res ? -w_div_quo : w_div_quo;
  assign w_rem_fix   = r_neg_rem ? -w_div_rem : w_div_rem;
  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= MD_ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MD_ST_IDLE: begin
        if (start) begin
          if (!w_is_div)      w_next_state = MD_ST_MUL;
`ifdef MD_DIV_EN
          else if (!w_b_zero) w_next_state = MD_ST_DIV;
`endif
          else                w_next_state = MD_ST_DONE;
        end
      end
      MD_ST_MUL, MD_ST_DIV: begin
        if (flush)              w_next_state = MD_ST_IDLE;
        else if (r_cnt == '0)   w_next_state = MD_ST_DONE;
      end
      default: w_next_state = MD_ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      MD_ST_MUL, MD_ST_DIV: busy = 1'b1;
      MD_ST_DONE:           done = 1'b1;
      default: ;
    endcase
    stall_req = busy | (start & (r_state == MD_ST_IDLE));
  end

  // NOTE: the whole datapath is reset because HI/LO and the counter have architectural reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_opnd    <= '0;
      r_neg_res <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef MD_DIV_EN
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
`endif
    end else begin
`ifdef MD_DIV_EN
      r_dbz <= 1'b0;
`endif
      case (r_state)
        MD_ST_IDLE: begin
          if (hilo_we[1]) r_hi <= hilo_wdata;
          if (hilo_we[0]) r_lo <= hilo_wdata;
          if (start) begin
            r_cnt     <= CNT_W'(DATA_W - 1);
            r_acc_hi  <= '0;
            r_acc_lo  <= w_is_div ? w_a_mag : w_b_mag;
            r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
            r_neg_res <= w_a_neg ^ w_b_neg;
`ifdef MD_DIV_EN
            r_neg_rem <= w_a_neg;
            r_dbz     <= w_is_div & w_b_zero;
`endif
          end
        end
        MD_ST_MUL: begin
          r_acc_hi <= w_mul_hi;
          r_acc_lo <= w_mul_lo;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else if (!flush) begin
            r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
            r_lo <= w_prod_fix[DATA_W-1:0];
          end
        end
`ifdef MD_DIV_EN
        MD_ST_DIV: begin
          r_acc_hi <= w_div_rem;
          r_acc_lo <= w_div_quo;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else if (!flush) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
        end
`endif
        MD_ST_DONE: begin
          if (hilo_we[1]) r_hi <= hilo_wdata;
          if (hilo_we[0]) r_lo <= hilo_wdata;
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed self-checking bench for md_seq_ctrl; expectations follow the MD_DIV_EN setting.
module tb_md_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  md_op, hilo_we;
  logic [31:0] srcA, srcB, hilo_wdata;
  logic        busy, stall_req, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat, bcnt;

  localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;

`ifdef MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  md_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .md_op      (md_op),
    .srcA       (srcA),
    .srcB       (srcB),
    .flush      (flush),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
    .busy       (busy),
    .stall_req  (stall_req),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Starts an op in the current cycle N; returns in the done cycle with lat = cycles after N.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int bc);
    start = 1'b1; md_op = op; srcA = a; srcB = b;
    bc = 0;
    step();
    start = 1'b0;
    l = 1;
    while (!done && l < 40) begin
      if (busy) bc++;
      step();
      l++;
    end
    if (!done) l = -1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; md_op = '0; hilo_we = '0;
    srcA = '0; srcB = '0; hilo_wdata = '0;
    step(); step(); step();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz",  64'(div_by_zero), 64'd0);
    check("rst_hi",   64'(hi), 64'd0);
    check("rst_lo",   64'(lo), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    step();

    // MULTU latency and busy window
    start = 1'b1; md_op = OP_MULTU; srcA = 32'hFFFF_FFFF; srcB = 32'h2;
    #1 check("t1_stall_idle_start", 64'(stall_req), 64'd1);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, lat, bcnt);
    check("t1_latency", 64'(lat), 64'd33);
    check("t1_busy_cycles", 64'(bcnt), 64'd32);
    check("t1_hi", 64'(hi), 64'h1);
    check("t1_lo", 64'(lo), 64'hFFFF_FFFE);
    check("t1_dbz", 64'(div_by_zero), 64'd0);
    check("t1_busy_in_done", 64'(busy), 64'd0);
    step();
    check("t1_idle_done", 64'(done), 64'd0);

    // signed multiply
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'h7, lat, bcnt);
    check("t2a_latency", 64'(lat), 64'd33);
    check("t2a_hi", 64'(hi), 64'hFFFF_FFFF);
    check("t2a_lo", 64'(lo), 64'hFFFF_FFEB);
    step();
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
    check("t2b_hi", 64'(hi), 64'h4000_0000);
    check("t2b_lo", 64'(lo), 64'h0);
    step();

    // divide
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
    check("t3a_latency", 64'(lat), DIV_EN ? 64'd33 : 64'd1);
    check("t3a_hi", 64'(hi), DIV_EN ? 64'd2  : 64'h4000_0000);
    check("t3a_lo", 64'(lo), DIV_EN ? 64'd14 : 64'h0);
    check("t3a_dbz", 64'(div_by_zero), 64'd0);
    step();
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    check("t3b_hi", 64'(hi), DIV_EN ? 64'hFFFF_FFFF : 64'h4000_0000);
    check("t3b_lo", 64'(lo), DIV_EN ? 64'hFFFF_FFFD : 64'h0);
    step();

    // divide by zero with preloaded HI/LO
    hilo_we = 2'b10; hilo_wdata = 32'hAA;
    step();
    check("t4_mthi", 64'(hi), 64'hAA);
    hilo_we = 2'b01; hilo_wdata = 32'hBB;
    step();
    hilo_we = 2'b00;
    check("t4_mtlo", 64'(lo), 64'hBB);
    run_op(OP_DIV, 32'd5, 32'd0, lat, bcnt);
    check("t4_latency", 64'(lat), 64'd1);
    check("t4_dbz", 64'(div_by_zero), DIV_EN ? 64'd1 : 64'd0);
    check("t4_hi", 64'(hi), 64'hAA);
    check("t4_lo", 64'(lo), 64'hBB);
    step();
    check("t4_dbz_clear", 64'(div_by_zero), 64'd0);
    check("t4_done_clear", 64'(done), 64'd0);

    // flush mid-multiply, then immediate restart
    start = 1'b1; md_op = OP_MULTU; srcA = 32'd3; srcB = 32'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("t5_busy_before_flush", 64'(busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_busy_after_flush", 64'(busy), 64'd0);
    check("t5_no_done", 64'(done), 64'd0);
    check("t5_hi_kept", 64'(hi), 64'hAA);
    check("t5_lo_kept", 64'(lo), 64'hBB);
    run_op(OP_MULTU, 32'd3, 32'd4, lat, bcnt);
    check("t5_restart_latency", 64'(lat), 64'd33);
    check("t5_hi", 64'(hi), 64'd0);
    check("t5_lo", 64'(lo), 64'd12);
    step();

    // synchronous reset during a divide
    start = 1'b1; md_op = OP_DIV; srcA = 32'd100; srcB = 32'd7;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    check("t6_rst_hi", 64'(hi), 64'd0);
    check("t6_rst_lo", 64'(lo), 64'd0);
    hilo_we = 2'b10; hilo_wdata = 32'h1234;
    step();
    hilo_we = 2'b00;
    check("t6_mthi", 64'(hi), 64'h1234);

    // MTLO and a second start during MUL are both ignored
    start = 1'b1; md_op = OP_MULTU; srcA = 32'd2; srcB = 32'd3;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; md_op = OP_MULT; srcA = 32'd9; srcB = 32'd9;
    hilo_we = 2'b01; hilo_wdata = 32'hDEAD;
    #1 check("t6_stall_busy", 64'(stall_req), 64'd1);
    step();
    start = 1'b0; hilo_we = 2'b00;
    check("t6_mtlo_ignored", 64'(lo), 64'd0);
    check("t6_still_busy", 64'(busy), 64'd1);
    lat = 4;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    check("t6_latency", 64'(lat), 64'd33);
    check("t6_hi", 64'(hi), 64'd0);
    check("t6_lo", 64'(lo), 64'd6);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
